// File: rtl/axis_pkt_tx.sv
// axis_pkt_tx: packetising AXI4-Stream source for the PL->PS DMA stream.
// Buffers a sample flow in a FIFO and emits fixed-length TLAST-framed packets.
module axis_pkt_tx #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int LW    = 16,
  parameter int CW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_en_i,
  input  logic [LW-1:0]   cfg_len_i,
  input  logic [DW-1:0]   smp_dat_i,
  input  logic            smp_vld_i,
  output logic [DW-1:0]   m_tdata_o,
  output logic [DW/8-1:0] m_tkeep_o,
  output logic            m_tlast_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i,
  output logic            busy_o,
  output logic [CW-1:0]   ovf_cnt_o,
  output logic [CW-1:0]   pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  state_t state;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, fill;
  logic          empty, full;
  logic [LW-1:0] beat_cnt, len_q, len_new, len_cur;
  logic          pkt_open, out_free, src_ok, load_fifo, load_pad, load, last_load;
  logic          drain_pop, rd_en, wr_req, wr_en, ovf, xfer, pkt_done;

  assign fill      = wr_ptr - rd_ptr;
  assign empty     = (fill == '0);
  assign full      = fill[AW];

  assign pkt_open  = (beat_cnt != '0);
  assign len_new   = (cfg_len_i == '0) ? LW'(1) : cfg_len_i;
  assign len_cur   = pkt_open ? len_q : len_new;
  assign last_load = (beat_cnt == len_cur - LW'(1));

  // A new packet may only be opened while enabled; an open one is always finished.
  assign out_free  = !m_tvalid_o || m_tready_i;
  assign src_ok    = ((state == RUN) && (cfg_en_i || pkt_open)) || ((state == FLUSH) && pkt_open);
  assign load_fifo = out_free && src_ok && !empty;
  assign load_pad  = out_free && (state == FLUSH) && pkt_open && empty;
  assign load      = load_fifo || load_pad;

  assign drain_pop = (state == DRAIN) && !empty;
  assign rd_en     = load_fifo || drain_pop;
  assign wr_req    = smp_vld_i && cfg_en_i && (state == RUN);
  assign wr_en     = wr_req && (!full || rd_en);
  assign ovf       = wr_req && full && !rd_en;
  assign xfer      = m_tvalid_o && m_tready_i;
  assign pkt_done  = !pkt_open && out_free;

  assign m_tkeep_o = '1;
  assign busy_o    = (state != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= smp_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat_cnt   <= '0;
      len_q      <= LW'(1);
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tvalid_o <= 1'b0;
      ovf_cnt_o  <= '0;
      pkt_cnt_o  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (ovf && (ovf_cnt_o != {CW{1'b1}})) ovf_cnt_o <= ovf_cnt_o + 1'b1;
      if (xfer && m_tlast_o) pkt_cnt_o <= pkt_cnt_o + 1'b1;

      // Skid register: reload whenever it is empty or its beat leaves this cycle.
      if (load) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= load_fifo ? mem[rd_ptr[AW-1:0]] : '0;
        m_tlast_o  <= last_load;
        if (!pkt_open) len_q <= len_new;
        beat_cnt   <= last_load ? '0 : beat_cnt + 1'b1;
      end else if (xfer) begin
        m_tvalid_o <= 1'b0;
      end

      case (state)
        IDLE:  if (cfg_en_i) state <= RUN;
        RUN:   if (!cfg_en_i) state <= pkt_done ? DRAIN : FLUSH;
        FLUSH: if (pkt_done) state <= DRAIN;
        DRAIN: if (empty && !m_tvalid_o) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// tb_axis_pkt_tx: directed table-driven bench for axis_pkt_tx with a transfer
// monitor, plus hand sequences for latency, overflow, length change and reset.
module tb_axis_pkt_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LW    = 16;
  localparam int CW    = 32;

  logic            clk_i;
  logic            rst_i;
  logic            cfg_en_i;
  logic [LW-1:0]   cfg_len_i;
  logic [DW-1:0]   smp_dat_i;
  logic            smp_vld_i;
  logic [DW-1:0]   m_tdata_o;
  logic [DW/8-1:0] m_tkeep_o;
  logic            m_tlast_o;
  logic            m_tvalid_o;
  logic            m_tready_i;
  logic            busy_o;
  logic [CW-1:0]   ovf_cnt_o;
  logic [CW-1:0]   pkt_cnt_o;

  axis_pkt_tx #(.DW(DW), .DEPTH(DEPTH), .LW(LW), .CW(CW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg_en_i   (cfg_en_i),
    .cfg_len_i  (cfg_len_i),
    .smp_dat_i  (smp_dat_i),
    .smp_vld_i  (smp_vld_i),
    .m_tdata_o  (m_tdata_o),
    .m_tkeep_o  (m_tkeep_o),
    .m_tlast_o  (m_tlast_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .busy_o     (busy_o),
    .ovf_cnt_o  (ovf_cnt_o),
    .pkt_cnt_o  (pkt_cnt_o)
  );

  typedef struct {
    int len;
    int nsamp;
    bit toggle;
    int exp_beats;
    int exp_pkts;
  } vec_t;

  vec_t          vecs [7];
  logic [DW:0]   beats [$];
  int            checks = 0;
  int            errors = 0;
  bit            toggle_mode = 1'b0;
  logic          hold_chk = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records every transfer and checks that a stalled beat stays put.
  always @(negedge clk_i) begin
    if (hold_chk) begin
      check_output("hold_valid", 64'(m_tvalid_o), 64'd1);
      check_output("hold_data", 64'(m_tdata_o), 64'(hold_d));
      check_output("hold_last", 64'(m_tlast_o), 64'(hold_l));
    end
    if (m_tvalid_o && m_tready_i && !rst_i) beats.push_back({m_tlast_o, m_tdata_o});
    hold_chk = m_tvalid_o && !m_tready_i && !rst_i;
    hold_d   = m_tdata_o;
    hold_l   = m_tlast_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (toggle_mode) m_tready_i = !m_tready_i;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic start(input int len);
    do_reset();
    beats.delete();
    cfg_len_i  = LW'(len);
    cfg_en_i   = 1'b1;
    m_tready_i = 1'b1;
    tick();
  endtask

  task automatic apply_stimulus(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      smp_vld_i = 1'b1;
      smp_dat_i = DW'(base + i);
      tick();
    end
    smp_vld_i = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (beats.size() < n) check_output({tag, "_beat_timeout"}, 64'(beats.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while ((busy_o || m_tvalid_o) && c < budget) begin
      tick();
      c++;
    end
    if (busy_o || m_tvalid_o) check_output({tag, "_idle_timeout"}, 64'(busy_o), 64'd0);
  endtask

  // Expected stream: ndata samples base+k, then zero pads; TLAST every max(len,1) beats.
  task automatic check_stream(input string tag, input int base, input int ndata,
                              input int len, input int exp_beats);
    int eff = (len == 0) ? 1 : len;
    int n;
    check_output({tag, "_beats"}, 64'(beats.size()), 64'(exp_beats));
    n = (beats.size() < exp_beats) ? beats.size() : exp_beats;
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] ed;
      logic          el;
      ed = (k < ndata) ? DW'(base + k) : '0;
      el = (((k + 1) % eff) == 0);
      check_output($sformatf("%s_data%0d", tag, k), 64'(beats[k][DW-1:0]), 64'(ed));
      check_output($sformatf("%s_last%0d", tag, k), 64'(beats[k][DW]), 64'(el));
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    cfg_en_i   = 1'b0;
    cfg_len_i  = LW'(4);
    smp_dat_i  = '0;
    smp_vld_i  = 1'b0;
    m_tready_i = 1'b1;

    vecs[0] = '{4, 8, 1'b0, 8, 2};
    vecs[1] = '{4, 8, 1'b1, 8, 2};
    vecs[2] = '{8, 3, 1'b0, 8, 1};
    vecs[3] = '{0, 3, 1'b0, 3, 3};
    vecs[4] = '{1, 5, 1'b1, 5, 5};
    vecs[5] = '{3, 7, 1'b1, 9, 3};
    vecs[6] = '{5, 10, 1'b1, 10, 2};

    do_reset();
    check_output("rst_tvalid", 64'(m_tvalid_o), 64'd0);
    check_output("rst_tlast", 64'(m_tlast_o), 64'd0);
    check_output("rst_tdata", 64'(m_tdata_o), 64'd0);
    check_output("rst_tkeep", 64'(m_tkeep_o), 64'hF);
    check_output("rst_busy", 64'(busy_o), 64'd0);
    check_output("rst_ovf", 64'(ovf_cnt_o), 64'd0);
    check_output("rst_pkt", 64'(pkt_cnt_o), 64'd0);

    for (int s = 0; s < 7; s++) begin
      string tag;
      tag = $sformatf("vec%0d", s);
      start(vecs[s].len);
      toggle_mode = vecs[s].toggle;
      apply_stimulus(32'h100 * (s + 1), vecs[s].nsamp);
      wait_beats(tag, vecs[s].nsamp, 200);
      cfg_en_i = 1'b0;
      wait_idle(tag, 200);
      toggle_mode = 1'b0;
      check_stream(tag, 32'h100 * (s + 1), vecs[s].nsamp, vecs[s].len, vecs[s].exp_beats);
      check_output({tag, "_pkts"}, 64'(pkt_cnt_o), 64'(vecs[s].exp_pkts));
      check_output({tag, "_ovf"}, 64'(ovf_cnt_o), 64'd0);
      check_output({tag, "_busy"}, 64'(busy_o), 64'd0);
    end

    // First sample reaches TVALID one edge after it is written.
    start(4);
    smp_vld_i = 1'b1;
    smp_dat_i = 32'h55;
    tick();
    smp_vld_i = 1'b0;
    check_output("lat_valid_n", 64'(m_tvalid_o), 64'd0);
    tick();
    check_output("lat_valid_n1", 64'(m_tvalid_o), 64'd1);
    check_output("lat_data_n1", 64'(m_tdata_o), 64'h55);
    cfg_en_i = 1'b0;
    wait_idle("lat", 100);
    check_stream("lat", 32'h55, 1, 4, 4);
    check_output("lat_pkts", 64'(pkt_cnt_o), 64'd1);

    // Overflow: 16 in FIFO plus 1 held in the output register, 3 dropped.
    start(4);
    m_tready_i = 1'b0;
    apply_stimulus(32'h3000, 20);
    check_output("ovf_cnt", 64'(ovf_cnt_o), 64'd3);
    check_output("ovf_tvalid", 64'(m_tvalid_o), 64'd1);
    check_output("ovf_tdata", 64'(m_tdata_o), 64'h3000);
    check_output("ovf_busy", 64'(busy_o), 64'd1);
    m_tready_i = 1'b1;
    wait_beats("ovf", 17, 100);
    cfg_en_i = 1'b0;
    wait_idle("ovf", 100);
    check_stream("ovf", 32'h3000, 17, 4, 20);
    check_output("ovf_pkts", 64'(pkt_cnt_o), 64'd5);
    check_output("ovf_cnt_end", 64'(ovf_cnt_o), 64'd3);

    // Write into a full FIFO while a read frees a slot is not an overflow.
    start(4);
    m_tready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 17) m_tready_i = 1'b1;
      smp_vld_i = 1'b1;
      smp_dat_i = DW'(32'h7000 + i);
      tick();
    end
    smp_vld_i = 1'b0;
    check_output("full_rw_ovf", 64'(ovf_cnt_o), 64'd0);
    wait_beats("full_rw", 20, 100);
    cfg_en_i = 1'b0;
    wait_idle("full_rw", 100);
    check_stream("full_rw", 32'h7000, 20, 4, 20);
    check_output("full_rw_pkts", 64'(pkt_cnt_o), 64'd5);

    // Length change mid-packet applies from the next packet.
    start(2);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cfg_len_i = LW'(3);
      smp_vld_i = 1'b1;
      smp_dat_i = DW'(32'h5000 + i);
      tick();
    end
    smp_vld_i = 1'b0;
    wait_beats("lenchg", 6, 100);
    cfg_en_i = 1'b0;
    wait_idle("lenchg", 100);
    check_output("lenchg_beats", 64'(beats.size()), 64'd8);
    for (int k = 0; k < 8 && k < beats.size(); k++) begin
      check_output($sformatf("lenchg_data%0d", k), 64'(beats[k][DW-1:0]),
                   (k < 6) ? 64'(32'h5000 + k) : 64'd0);
      check_output($sformatf("lenchg_last%0d", k), 64'(beats[k][DW]),
                   (k == 1 || k == 4 || k == 7) ? 64'd1 : 64'd0);
    end
    check_output("lenchg_pkts", 64'(pkt_cnt_o), 64'd3);

    // Reset mid-packet aborts everything; restart begins a fresh packet.
    start(4);
    apply_stimulus(32'h6000, 4);
    wait_beats("rstmid_a", 4, 100);
    check_output("rstmid_pkts_pre", 64'(pkt_cnt_o), 64'd1);
    m_tready_i = 1'b0;
    apply_stimulus(32'h6100, 20);
    check_output("rstmid_ovf_pre", 64'(ovf_cnt_o), 64'd3);
    check_output("rstmid_valid_pre", 64'(m_tvalid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check_output("rstmid_valid", 64'(m_tvalid_o), 64'd0);
    check_output("rstmid_tlast", 64'(m_tlast_o), 64'd0);
    check_output("rstmid_pkts", 64'(pkt_cnt_o), 64'd0);
    check_output("rstmid_ovf", 64'(ovf_cnt_o), 64'd0);
    check_output("rstmid_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    beats.delete();
    m_tready_i = 1'b1;
    tick();
    apply_stimulus(32'h6200, 4);
    wait_beats("rstmid_b", 4, 100);
    cfg_en_i = 1'b0;
    wait_idle("rstmid", 100);
    check_stream("rstmid", 32'h6200, 4, 4, 4);
    check_output("rstmid_pkts_post", 64'(pkt_cnt_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
